// File: rtl/fft_spectrum_reader_if.sv
// Interface between the FFT result port, the display read port and the
// spectrum reader. The reader uses the slave modport. The FFT/display side
// uses the master modport.
interface fft_spectrum_reader_if #(
  parameter int unsigned RN = 16,
  parameter int unsigned AW = 6
);
  logic          fft_done;
  logic          fft_shift;
  logic [RN-1:0] fft_data;
  logic          freeze;
  logic [AW-1:0] rd_addr;
  logic [RN-1:0] rd_data;
  logic          frame_valid;
  logic          overrun;
  logic          busy;

  modport slave (
    input  fft_done, fft_data, freeze, rd_addr,
    output fft_shift, rd_data, frame_valid, overrun, busy
  );

  modport master (
    output fft_done, fft_data, freeze, rd_addr,
    input  fft_shift, rd_data, frame_valid, overrun, busy
  );
endinterface

// File: rtl/fft_spectrum_reader.sv
// FFT spectrum reader: streams SIZE bins out of the FFT after each done pulse,
// captures them into the back bank of a double-buffered store, and swaps banks
// once the whole frame has landed. The display reads the front bank through
// a registered port.
// Optional build macro FFT_READER_PEAK_HOLD_EN: each stored bin becomes
// max(fft_data, prev - 1), where prev is the same bin in the current front bank.
module fft_spectrum_reader #(
  parameter int unsigned RN   = 16,
  parameter int unsigned SIZE = 64,
  parameter int unsigned AW   = $clog2(SIZE),
  parameter int unsigned LAT  = 2
) (
  input logic                  clk,
  input logic                  n_reset,
  fft_spectrum_reader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDrain, StSwap} state_e;

  localparam logic [AW-1:0] LastBin   = AW'(SIZE - 1);
  // The final capture lands in the SWAP cycle itself, so DRAIN covers LAT-1
  // cycles. DRAIN always lasts at least one cycle.
  localparam logic [AW-1:0] DrainLast = AW'((LAT > 1) ? (LAT - 2) : 0);

  state_e          state;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cap_idx;
  logic            front;
  logic [LAT-1:0]  shift_dly;
  logic            cap_en;
  logic            start;
  logic [RN-1:0]   wr_val;
  logic [RN-1:0]   mem [2*SIZE];

  assign start  = (state == StIdle) && bus.fft_done && !bus.freeze;
  assign cap_en = shift_dly[LAT-1];

  // Frame sequencer with registered shift/busy/status outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state           <= StIdle;
      cnt             <= '0;
      front           <= 1'b0;
      bus.fft_shift   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      if (bus.fft_done && (state != StIdle)) bus.overrun <= 1'b1;
      unique case (state)
        StIdle: begin
          if (start) begin
            state         <= StShift;
            cnt           <= '0;
            bus.fft_shift <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        StShift: begin
          if (cnt == LastBin) begin
            state         <= StDrain;
            cnt           <= '0;
            bus.fft_shift <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        StDrain: begin
          if (cnt == DrainLast) state <= StSwap;
          else                  cnt   <= cnt + AW'(1);
        end
        StSwap: begin
          front           <= ~front;
          bus.frame_valid <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Delay fft_shift by LAT cycles to line up with fft_data and track the bin
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_dly <= '0;
      cap_idx   <= '0;
    end else begin
      shift_dly[0] <= bus.fft_shift;
      for (int i = 1; i < LAT; i++) shift_dly[i] <= shift_dly[i-1];
      if (start)       cap_idx <= '0;
      else if (cap_en) cap_idx <= cap_idx + AW'(1);
    end
  end

`ifdef FFT_READER_PEAK_HOLD_EN
  logic [RN-1:0] prev_q;
  logic [RN-1:0] prev_m1;
  logic [AW-1:0] pre_idx;

  // Next bin to capture: cap_idx advances on every cap_en
  assign pre_idx = cap_idx + AW'(cap_en);

  // Second front-bank read port, one cycle ahead of the matching capture
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) prev_q <= '0;
    else          prev_q <= bus.frame_valid ? mem[{front, pre_idx}] : '0;
  end

  assign prev_m1 = (prev_q == '0) ? '0 : (prev_q - RN'(1));
  assign wr_val  = (bus.fft_data >= prev_m1) ? bus.fft_data : prev_m1;
`else
  assign wr_val = bus.fft_data;
`endif

  // Back-bank write; the memory is deliberately left unreset
  always_ff @(posedge clk) begin
    if (cap_en) mem[{~front, cap_idx}] <= wr_val;
  end

  // Registered display read of the front bank
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) bus.rd_data <= '0;
    else          bus.rd_data <= mem[{front, bus.rd_addr}];
  end

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Directed bench for fft_spectrum_reader with SIZE=64, LAT=2.
// A small FFT model returns the bin pattern LAT cycles after each shift.
module tb_fft_spectrum_reader;
  localparam int unsigned RN   = 16;
  localparam int unsigned SIZE = 64;
  localparam int unsigned AW   = 6;
  localparam int unsigned LAT  = 2;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  fft_spectrum_reader_if #(.RN(RN), .AW(AW)) bus ();

  fft_spectrum_reader #(.RN(RN), .SIZE(SIZE), .AW(AW), .LAT(LAT)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // FFT model state
  int mode = 0;
  int peak_val = 0;
  int total_shifts = 0;
  int run = 0;
  int pipe_bin [LAT+1];
  bit pipe_v [LAT+1];
  logic [RN-1:0] rd_hist [0:1023];

  function automatic logic [RN-1:0] gen(input int k);
    case (mode)
      0:       return RN'(100 + k);
      1:       return RN'(500 - k);
      default: return (k == 3) ? RN'(peak_val) : RN'(0);
    endcase
  endfunction

  initial begin
    for (int i = 0; i <= LAT; i++) begin
      pipe_bin[i] = 0;
      pipe_v[i]   = 1'b0;
    end
  end

  // Bin k is presented on fft_data during the cycle LAT after its shift
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      pipe_bin[i] = pipe_bin[i-1];
      pipe_v[i]   = pipe_v[i-1];
    end
    pipe_v[0]   = bus.fft_shift;
    pipe_bin[0] = run;
    if (bus.fft_shift) begin
      run++;
      total_shifts++;
    end else begin
      run = 0;
    end
    bus.fft_data = pipe_v[LAT] ? gen(pipe_bin[LAT]) : 16'hdead;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [RN-1:0] d);
    @(negedge clk) bus.rd_addr = a;
    @(negedge clk) d = bus.rd_data;
  endtask

  // One frame: pulse fft_done, optionally re-pulse or raise freeze at a given
  // cycle; returns cycles until busy falls and the number of shifts seen.
  task automatic run_frame(input int redo_at, input int frz_at,
                           output int turn, output int nshift);
    int s0;
    s0 = total_shifts;
    @(negedge clk) bus.fft_done = 1'b1;
    @(negedge clk) bus.fft_done = 1'b0;
    turn = 1;
    rd_hist[1] = bus.rd_data;
    while (bus.busy && turn < 1000) begin
      @(negedge clk);
      turn++;
      rd_hist[turn] = bus.rd_data;
      bus.fft_done = (turn == redo_at);
      if (turn == frz_at) bus.freeze = 1'b1;
    end
    bus.fft_done = 1'b0;
    @(negedge clk);
    rd_hist[turn+1] = bus.rd_data;
    nshift = total_shifts - s0;
    bus.freeze = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [RN-1:0] exp;
  } vec_t;

  vec_t v1 [4];
  vec_t v2 [4];

  initial begin
    int turn, nsh, bad, s0;
    logic [RN-1:0] d;

    v1[0] = '{6'd0,  16'd100};
    v1[1] = '{6'd5,  16'd105};
    v1[2] = '{6'd31, 16'd131};
    v1[3] = '{6'd63, 16'd163};
    v2[0] = '{6'd0,  16'd500};
    v2[1] = '{6'd1,  16'd499};
    v2[2] = '{6'd40, 16'd460};
    v2[3] = '{6'd63, 16'd437};

    n_reset      = 1'b0;
    bus.fft_done = 1'b0;
    bus.freeze   = 1'b0;
    bus.rd_addr  = '0;
    repeat (2) @(negedge clk);
    check("reset fft_shift", 32'(bus.fft_shift), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset frame_valid", 32'(bus.frame_valid), 0);
    check("reset overrun", 32'(bus.overrun), 0);
    check("reset rd_data", 32'(bus.rd_data), 0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: 100+k
    mode = 0;
    run_frame(0, 0, turn, nsh);
    check("f1 turnaround", 32'(turn), 67);
    check("f1 shifts", 32'(nsh), 64);
    check("f1 frame_valid", 32'(bus.frame_valid), 1);
    check("f1 overrun", 32'(bus.overrun), 0);
    for (int i = 0; i < 4; i++) begin
      rd(v1[i].addr, d);
      check($sformatf("f1 rd[%0d]", v1[i].addr), 32'(d), 32'(v1[i].exp));
    end

    // Frame 2: 500-k, watching bin 0 across the swap
    mode = 1;
    @(negedge clk) bus.rd_addr = '0;
    run_frame(0, 0, turn, nsh);
    check("f2 turnaround", 32'(turn), 67);
    bad = 0;
    for (int c = 1; c <= 66; c++) if (rd_hist[c] !== 16'd100) bad++;
    check("f2 old bank held", 32'(bad), 0);
    check("f2 rd in swap cycle", 32'(rd_hist[67]), 100);
    check("f2 rd after swap", 32'(rd_hist[68]), 500);
    for (int i = 0; i < 4; i++) begin
      rd(v2[i].addr, d);
      check($sformatf("f2 rd[%0d]", v2[i].addr), 32'(d), 32'(v2[i].exp));
    end

    // fft_done while frozen in IDLE is dropped
    mode = 0;
    s0 = total_shifts;
    bus.freeze = 1'b1;
    @(negedge clk) bus.fft_done = 1'b1;
    @(negedge clk) bus.fft_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.busy !== 1'b0 || bus.fft_shift !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.freeze = 1'b0;
    check("frz idle busy/shift", 32'(bad), 0);
    check("frz idle shifts", 32'(total_shifts - s0), 0);
    check("frz idle overrun", 32'(bus.overrun), 0);
    rd(6'd0, d);
    check("frz idle front held", 32'(d), 500);

    // freeze raised mid-SHIFT still swaps
    mode = 0;
    run_frame(0, 20, turn, nsh);
    check("frz mid turnaround", 32'(turn), 67);
    check("frz mid shifts", 32'(nsh), 64);
    rd(6'd0, d);
    check("frz mid swapped", 32'(d), 100);

    // fft_done during SHIFT sets a sticky overrun
    mode = 1;
    run_frame(10, 0, turn, nsh);
    check("ovr flag", 32'(bus.overrun), 1);
    check("ovr turnaround", 32'(turn), 67);
    check("ovr shifts", 32'(nsh), 64);
    rd(6'd2, d);
    check("ovr rd[2]", 32'(d), 498);
    repeat (5) @(negedge clk);
    check("ovr sticky", 32'(bus.overrun), 1);

    // Reset mid-frame at shift count 30
    @(negedge clk) n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    mode = 0;
    @(negedge clk) bus.fft_done = 1'b1;
    @(negedge clk) bus.fft_done = 1'b0;
    repeat (30) @(negedge clk);
    check("pre-reset shifting", 32'(bus.fft_shift), 1);
    n_reset = 1'b0;
    #1;
    check("midrst fft_shift", 32'(bus.fft_shift), 0);
    check("midrst busy", 32'(bus.busy), 0);
    check("midrst frame_valid", 32'(bus.frame_valid), 0);
    check("midrst overrun", 32'(bus.overrun), 0);
    check("midrst rd_data", 32'(bus.rd_data), 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("midrst stays invalid", 32'(bad), 0);
    run_frame(0, 0, turn, nsh);
    check("midrst frame turnaround", 32'(turn), 67);
    check("midrst frame_valid", 32'(bus.frame_valid), 1);
    rd(6'd5, d);
    check("midrst rd[5]", 32'(d), 105);

`ifdef FFT_READER_PEAK_HOLD_EN
    begin
      int pv [4];
      int pe [4];
      pv = '{200, 50, 50, 250};
      pe = '{200, 199, 198, 250};
      mode = 2;
      for (int i = 0; i < 4; i++) begin
        peak_val = pv[i];
        run_frame(0, 0, turn, nsh);
        rd(6'd3, d);
        check($sformatf("peak frame %0d bin3", i), 32'(d), 32'(pe[i]));
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
